// File: rtl/ifq_param_pkg.sv
// Shared types and helpers for the parametrised instruction fetch queue.
// Defaults describe the baseline 4-line x 4-word configuration.
package ifq_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int DEPTH_DEF      = 4;
  localparam int OFF_W          = $clog2(LINE_WORDS_DEF);
  localparam int PTR_W          = $clog2(DEPTH_DEF);
  localparam int LINE_BYTES     = 4 * LINE_WORDS_DEF;

  typedef logic [LINE_WORDS_DEF-1:0][31:0] line_t;

  // Clears the byte-in-word and word-in-line bits of an address.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned offW);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (offW + 2);
    return addr & mask;
  endfunction

endpackage

// File: rtl/ifq_param_if.sv
// Cache-side and dispatcher-side signals of the fetch queue.
// master = the queue itself, slave = the surrounding cache/dispatcher.
interface ifq_param_if #(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 4
);

  logic [31:0]              o_cache_addr;
  logic                     o_cache_rd_en;
  logic                     o_abort;
  logic [32*LINE_WORDS-1:0] i_cache_dout;
  logic                     i_cache_dout_valid;
  logic                     i_rd_en;
  logic [31:0]              i_jmp_branch_address;
  logic                     i_jmp_branch_valid;
  logic [31:0]              o_instr;
  logic [31:0]              o_pc_out;
  logic                     o_empty;
  logic [$clog2(DEPTH):0]   o_count;

  modport master (
    output o_cache_addr, o_cache_rd_en, o_abort, o_instr, o_pc_out, o_empty, o_count,
    input  i_cache_dout, i_cache_dout_valid, i_rd_en, i_jmp_branch_address, i_jmp_branch_valid
  );

  modport slave (
    input  o_cache_addr, o_cache_rd_en, o_abort, o_instr, o_pc_out, o_empty, o_count,
    output i_cache_dout, i_cache_dout_valid, i_rd_en, i_jmp_branch_address, i_jmp_branch_valid
  );

endinterface

// File: rtl/ifq_param_line_buf.sv
// DEPTH x line storage with one line-wide write port and one word-wide read port.
// Contents are deliberately not reset; validity is tracked by the queue count.
module ifq_line_buf #(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(DEPTH)-1:0]      wptr_i,
  input  logic [32*LINE_WORDS-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0]      rptr_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wsel_i,
  output logic [31:0]                   word_o
);

  logic [LINE_WORDS-1:0][31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wptr_i] <= wdata_i;
    end
  end

  assign word_o = mem_q[rptr_i][wsel_i];

endmodule

// File: rtl/ifq_param.sv
// Instruction fetch queue: line-aligned cache reads in, one instruction per cycle out,
// with flush and mid-line restart on a dispatcher redirect.
module ifq_param
  import ifq_pkg::*;
#(
  parameter int          LINE_WORDS = LINE_WORDS_DEF,
  parameter int          DEPTH      = DEPTH_DEF,
  parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
  input logic         i_clk,
  input logic         i_rst_n,
  ifq_param_if.master bus
);

  localparam int          OFF    = $clog2(LINE_WORDS);
  localparam int          PTRW   = $clog2(DEPTH);
  localparam int          CNTW   = PTRW + 1;
  localparam logic [31:0] LBYTES = 32'(4 * LINE_WORDS);

  logic [31:0]     fetchPc_q, fetchPc_d;
  logic [31:0]     rdPc_q, rdPc_d;
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [OFF-1:0]  wordOff_q, wordOff_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            outstanding_q, outstanding_d;

  logic        empty;
  logic        reqFire;
  logic        fill;
  logic        consume;
  logic        retire;
  logic        jmp;
  logic [31:0] bufWord;
  logic        unusedAddrBits;

  assign jmp            = bus.i_jmp_branch_valid;
  assign empty          = (count_q == '0);
  assign unusedAddrBits = ^bus.i_jmp_branch_address[1:0];

  // Requests and aborts are held off while reset is asserted so a reset mid-request stays silent.
  assign reqFire = i_rst_n & ~outstanding_q & ~jmp
                 & ((count_q + CNTW'(outstanding_q)) < CNTW'(DEPTH));
  assign fill    = bus.i_cache_dout_valid & ~jmp;
  assign consume = bus.i_rd_en & ~empty & ~jmp;
  assign retire  = consume & (wordOff_q == OFF'(LINE_WORDS - 1));

  always_comb begin
    fetchPc_d     = fetchPc_q;
    rdPc_d        = rdPc_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    wordOff_d     = wordOff_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;

    if (jmp) begin
      fetchPc_d     = {bus.i_jmp_branch_address[31:2], 2'b00};
      rdPc_d        = {bus.i_jmp_branch_address[31:2], 2'b00};
      wordOff_d     = bus.i_jmp_branch_address[OFF+1:2];
      wptr_d        = '0;
      rptr_d        = '0;
      count_d       = '0;
      outstanding_d = 1'b0;
    end else begin
      if (bus.i_cache_dout_valid) begin
        outstanding_d = 1'b0;
      end
      if (reqFire) begin
        outstanding_d = 1'b1;
      end
      if (fill) begin
        wptr_d    = wptr_q + 1'b1;
        fetchPc_d = fetchPc_q + LBYTES;
      end
      // Word offset wraps to 0 at line end, so only the first line after a redirect starts mid-line.
      if (consume) begin
        rdPc_d = rdPc_q + 32'd4;
        if (retire) begin
          wordOff_d = '0;
          rptr_d    = rptr_q + 1'b1;
        end else begin
          wordOff_d = wordOff_q + 1'b1;
        end
      end
      count_d = count_q + CNTW'(fill) - CNTW'(retire);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetchPc_q     <= RESET_PC;
      rdPc_q        <= RESET_PC;
      wptr_q        <= '0;
      rptr_q        <= '0;
      wordOff_q     <= '0;
      count_q       <= '0;
      outstanding_q <= 1'b0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      rdPc_q        <= rdPc_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      wordOff_q     <= wordOff_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
    end
  end

  ifq_line_buf #(
    .LINE_WORDS(LINE_WORDS),
    .DEPTH     (DEPTH)
  ) u_line_buf (
    .clk_i  (i_clk),
    .we_i   (fill),
    .wptr_i (wptr_q),
    .wdata_i(bus.i_cache_dout),
    .rptr_i (rptr_q),
    .wsel_i (wordOff_q),
    .word_o (bufWord)
  );

  assign bus.o_cache_rd_en = reqFire;
  assign bus.o_abort       = i_rst_n & jmp & outstanding_q;
  assign bus.o_cache_addr  = line_base(fetchPc_q, 32'(OFF));
  assign bus.o_empty       = empty;
  assign bus.o_instr       = empty ? 32'd0 : bufWord;
  assign bus.o_pc_out      = rdPc_q + 32'd4;
  assign bus.o_count       = count_q;

endmodule

// File: tb/tb_ifq_param.sv
// Directed bench for ifq_param: default 4x4 instance plus an 8-word/2-line instance.
module tb_ifq_param;

  logic clk;
  logic rstN;
  int   passCount;
  int   checkCount;

  ifq_param_if #(.LINE_WORDS(4), .DEPTH(4)) busA ();
  ifq_param_if #(.LINE_WORDS(8), .DEPTH(2)) busB ();

  ifq_param #(.LINE_WORDS(4), .DEPTH(4), .RESET_PC(32'h0040_0000)) dutA (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .bus    (busA)
  );

  ifq_param #(.LINE_WORDS(8), .DEPTH(2), .RESET_PC(32'h0040_0000)) dutB (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .bus    (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache contents model: word k of the line at lineAddr.
  function automatic logic [31:0] wordOf(input logic [31:0] lineAddr, input int k);
    return (lineAddr - 32'h0040_0000) + 32'(k + 1) * 32'h11;
  endfunction

  function automatic logic [255:0] lineData(input logic [31:0] lineAddr, input int lw);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < lw; k++) v[32*k +: 32] = wordOf(lineAddr, k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    busA.i_cache_dout = '0;
    busA.i_cache_dout_valid = 1'b0;
    busA.i_rd_en = 1'b0;
    busA.i_jmp_branch_address = '0;
    busA.i_jmp_branch_valid = 1'b0;
    busB.i_cache_dout = '0;
    busB.i_cache_dout_valid = 1'b0;
    busB.i_rd_en = 1'b0;
    busB.i_jmp_branch_address = '0;
    busB.i_jmp_branch_valid = 1'b0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle out of reset.
  task automatic doReset();
    rstN = 1'b0;
    clearInputs();
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    clearInputs();
    tick();
    tick();
    #1;
    checkCount++; if (busA.o_empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", busA.o_empty); else passCount++;
    checkCount++; if (busA.o_instr !== 32'h0) $display("[TB] FAIL reset_instr: got %h expected 0", busA.o_instr); else passCount++;
    checkCount++; if (busA.o_pc_out !== 32'h0040_0004) $display("[TB] FAIL reset_pc: got %h expected 00400004", busA.o_pc_out); else passCount++;
    checkCount++; if (busA.o_cache_rd_en !== 1'b0) $display("[TB] FAIL reset_rd_en: got %b expected 0", busA.o_cache_rd_en); else passCount++;
    checkCount++; if (busA.o_abort !== 1'b0) $display("[TB] FAIL reset_abort: got %b expected 0", busA.o_abort); else passCount++;
    checkCount++; if (busA.o_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", busA.o_count); else passCount++;
  endtask

  task automatic test_basic();
    logic [255:0] tmp;
    logic [31:0]  expInstr [4];
    expInstr[0] = 32'h11; expInstr[1] = 32'h22; expInstr[2] = 32'h33; expInstr[3] = 32'h44;
    doReset();
    busA.i_rd_en = 1'b1;
    #1;
    checkCount++; if (busA.o_cache_rd_en !== 1'b1) $display("[TB] FAIL basic_req: got %b expected 1", busA.o_cache_rd_en); else passCount++;
    checkCount++; if (busA.o_cache_addr !== 32'h0040_0000) $display("[TB] FAIL basic_addr: got %h expected 00400000", busA.o_cache_addr); else passCount++;
    tick();
    #1;
    checkCount++; if (busA.o_cache_rd_en !== 1'b0) $display("[TB] FAIL basic_req_held: got %b expected 0", busA.o_cache_rd_en); else passCount++;
    tick();
    tmp = lineData(32'h0040_0000, 4);
    busA.i_cache_dout = tmp[127:0];
    busA.i_cache_dout_valid = 1'b1;
    #1;
    checkCount++; if (busA.o_empty !== 1'b1) $display("[TB] FAIL basic_no_bypass: got %b expected 1", busA.o_empty); else passCount++;
    tick();
    busA.i_cache_dout_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkCount++; if (busA.o_empty !== 1'b0) $display("[TB] FAIL basic_empty%0d: got %b expected 0", k, busA.o_empty); else passCount++;
      checkCount++; if (busA.o_instr !== expInstr[k]) $display("[TB] FAIL basic_instr%0d: got %h expected %h", k, busA.o_instr, expInstr[k]); else passCount++;
      checkCount++; if (busA.o_pc_out !== 32'h0040_0004 + 32'(4*k)) $display("[TB] FAIL basic_pc%0d: got %h expected %h", k, busA.o_pc_out, 32'h0040_0004 + 32'(4*k)); else passCount++;
      tick();
    end
    #1;
    checkCount++; if (busA.o_empty !== 1'b1) $display("[TB] FAIL basic_drained: got %b expected 1", busA.o_empty); else passCount++;
  endtask

  task automatic test_full();
    logic [255:0] tmp;
    logic [31:0]  addr;
    doReset();
    for (int i = 0; i < 4; i++) begin
      addr = 32'h0040_0000 + 32'(16*i);
      #1;
      checkCount++; if (busA.o_cache_rd_en !== 1'b1) $display("[TB] FAIL full_req%0d: got %b expected 1", i, busA.o_cache_rd_en); else passCount++;
      checkCount++; if (busA.o_cache_addr !== addr) $display("[TB] FAIL full_addr%0d: got %h expected %h", i, busA.o_cache_addr, addr); else passCount++;
      tick();
      tick();
      tmp = lineData(addr, 4);
      busA.i_cache_dout = tmp[127:0];
      busA.i_cache_dout_valid = 1'b1;
      tick();
      busA.i_cache_dout_valid = 1'b0;
    end
    #1;
    checkCount++; if (busA.o_cache_rd_en !== 1'b0) $display("[TB] FAIL full_stall: got %b expected 0", busA.o_cache_rd_en); else passCount++;
    checkCount++; if (busA.o_count !== 3'd4) $display("[TB] FAIL full_count: got %0d expected 4", busA.o_count); else passCount++;
    busA.i_rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkCount++; if (busA.o_instr !== 32'(k + 1) * 32'h11) $display("[TB] FAIL full_instr%0d: got %h expected %h", k, busA.o_instr, 32'(k + 1) * 32'h11); else passCount++;
      checkCount++; if (busA.o_cache_rd_en !== 1'b0) $display("[TB] FAIL full_hold%0d: got %b expected 0", k, busA.o_cache_rd_en); else passCount++;
      tick();
    end
    busA.i_rd_en = 1'b0;
    #1;
    checkCount++; if (busA.o_cache_rd_en !== 1'b1) $display("[TB] FAIL full_refill_req: got %b expected 1", busA.o_cache_rd_en); else passCount++;
    checkCount++; if (busA.o_cache_addr !== 32'h0040_0040) $display("[TB] FAIL full_refill_addr: got %h expected 00400040", busA.o_cache_addr); else passCount++;
    checkCount++; if (busA.o_count !== 3'd3) $display("[TB] FAIL full_after_retire: got %0d expected 3", busA.o_count); else passCount++;
  endtask

  task automatic test_redirect();
    logic [255:0] tmp;
    doReset();
    tick();
    busA.i_jmp_branch_address = 32'h0000_1008;
    busA.i_jmp_branch_valid = 1'b1;
    #1;
    checkCount++; if (busA.o_abort !== 1'b1) $display("[TB] FAIL redir_abort: got %b expected 1", busA.o_abort); else passCount++;
    checkCount++; if (busA.o_cache_rd_en !== 1'b0) $display("[TB] FAIL redir_no_req: got %b expected 0", busA.o_cache_rd_en); else passCount++;
    tick();
    busA.i_jmp_branch_valid = 1'b0;
    #1;
    checkCount++; if (busA.o_cache_addr !== 32'h0000_1000) $display("[TB] FAIL redir_addr: got %h expected 00001000", busA.o_cache_addr); else passCount++;
    checkCount++; if (busA.o_empty !== 1'b1) $display("[TB] FAIL redir_empty: got %b expected 1", busA.o_empty); else passCount++;
    checkCount++; if (busA.o_cache_rd_en !== 1'b1) $display("[TB] FAIL redir_req: got %b expected 1", busA.o_cache_rd_en); else passCount++;
    tick();
    tick();
    tmp = lineData(32'h0000_1000, 4);
    busA.i_cache_dout = tmp[127:0];
    busA.i_cache_dout_valid = 1'b1;
    tick();
    busA.i_cache_dout_valid = 1'b0;
    busA.i_rd_en = 1'b1;
    #1;
    checkCount++; if (busA.o_instr !== 32'hFFC0_1033) $display("[TB] FAIL redir_instr2: got %h expected ffc01033", busA.o_instr); else passCount++;
    checkCount++; if (busA.o_pc_out !== 32'h0000_100C) $display("[TB] FAIL redir_pc2: got %h expected 0000100c", busA.o_pc_out); else passCount++;
    tick();
    #1;
    checkCount++; if (busA.o_instr !== 32'hFFC0_1044) $display("[TB] FAIL redir_instr3: got %h expected ffc01044", busA.o_instr); else passCount++;
    checkCount++; if (busA.o_pc_out !== 32'h0000_1010) $display("[TB] FAIL redir_pc3: got %h expected 00001010", busA.o_pc_out); else passCount++;
    tick();
    busA.i_rd_en = 1'b0;
    #1;
    checkCount++; if (busA.o_empty !== 1'b1) $display("[TB] FAIL redir_line_done: got %b expected 1", busA.o_empty); else passCount++;
  endtask

  task automatic test_collide();
    logic [255:0] tmp;
    doReset();
    tick();
    tick();
    tmp = lineData(32'h0040_0000, 4);
    busA.i_cache_dout = tmp[127:0];
    busA.i_cache_dout_valid = 1'b1;
    tick();
    busA.i_cache_dout_valid = 1'b0;
    #1;
    checkCount++; if (busA.o_count !== 3'd1) $display("[TB] FAIL coll_count1: got %0d expected 1", busA.o_count); else passCount++;
    checkCount++; if (busA.o_cache_rd_en !== 1'b1) $display("[TB] FAIL coll_req2: got %b expected 1", busA.o_cache_rd_en); else passCount++;
    tick();
    tick();
    tmp = lineData(32'h0040_0010, 4);
    busA.i_cache_dout = tmp[127:0];
    busA.i_cache_dout_valid = 1'b1;
    busA.i_rd_en = 1'b1;
    busA.i_jmp_branch_address = 32'h0000_2004;
    busA.i_jmp_branch_valid = 1'b1;
    #1;
    checkCount++; if (busA.o_abort !== 1'b1) $display("[TB] FAIL coll_abort: got %b expected 1", busA.o_abort); else passCount++;
    tick();
    clearInputs();
    #1;
    checkCount++; if (busA.o_count !== 3'd0) $display("[TB] FAIL coll_count0: got %0d expected 0", busA.o_count); else passCount++;
    checkCount++; if (busA.o_empty !== 1'b1) $display("[TB] FAIL coll_empty: got %b expected 1", busA.o_empty); else passCount++;
    checkCount++; if (busA.o_pc_out !== 32'h0000_2008) $display("[TB] FAIL coll_pc: got %h expected 00002008", busA.o_pc_out); else passCount++;
    checkCount++; if (busA.o_cache_addr !== 32'h0000_2000) $display("[TB] FAIL coll_addr: got %h expected 00002000", busA.o_cache_addr); else passCount++;
  endtask

  task automatic test_sweep();
    doReset();
    #1;
    checkCount++; if (busB.o_cache_addr !== 32'h0040_0000) $display("[TB] FAIL sweep_addr0: got %h expected 00400000", busB.o_cache_addr); else passCount++;
    tick();
    busB.i_jmp_branch_address = 32'hFFFF_FFFC;
    busB.i_jmp_branch_valid = 1'b1;
    #1;
    checkCount++; if (busB.o_abort !== 1'b1) $display("[TB] FAIL sweep_abort: got %b expected 1", busB.o_abort); else passCount++;
    tick();
    busB.i_jmp_branch_valid = 1'b0;
    #1;
    checkCount++; if (busB.o_cache_addr !== 32'hFFFF_FFE0) $display("[TB] FAIL sweep_addr: got %h expected ffffffe0", busB.o_cache_addr); else passCount++;
    tick();
    tick();
    busB.i_cache_dout = lineData(32'hFFFF_FFE0, 8);
    busB.i_cache_dout_valid = 1'b1;
    tick();
    busB.i_cache_dout_valid = 1'b0;
    busB.i_rd_en = 1'b1;
    #1;
    checkCount++; if (busB.o_instr !== 32'hFFC0_0068) $display("[TB] FAIL sweep_instr7: got %h expected ffc00068", busB.o_instr); else passCount++;
    checkCount++; if (busB.o_pc_out !== 32'h0000_0000) $display("[TB] FAIL sweep_pc_wrap: got %h expected 00000000", busB.o_pc_out); else passCount++;
    checkCount++; if (busB.o_cache_addr !== 32'h0000_0000) $display("[TB] FAIL sweep_fetch_wrap: got %h expected 00000000", busB.o_cache_addr); else passCount++;
    checkCount++; if (busB.o_cache_rd_en !== 1'b1) $display("[TB] FAIL sweep_req: got %b expected 1", busB.o_cache_rd_en); else passCount++;
    checkCount++; if (busB.o_count !== 2'd1) $display("[TB] FAIL sweep_count1: got %0d expected 1", busB.o_count); else passCount++;
    tick();
    busB.i_rd_en = 1'b0;
    #1;
    checkCount++; if (busB.o_empty !== 1'b1) $display("[TB] FAIL sweep_retired: got %b expected 1", busB.o_empty); else passCount++;
  endtask

  task automatic test_reset_mid();
    logic [255:0] tmp;
    logic [31:0]  addr;
    doReset();
    for (int i = 0; i < 3; i++) begin
      addr = 32'h0040_0000 + 32'(16*i);
      tick();
      tick();
      tmp = lineData(addr, 4);
      busA.i_cache_dout = tmp[127:0];
      busA.i_cache_dout_valid = 1'b1;
      tick();
      busA.i_cache_dout_valid = 1'b0;
    end
    #1;
    checkCount++; if (busA.o_count !== 3'd3) $display("[TB] FAIL rstmid_count3: got %0d expected 3", busA.o_count); else passCount++;
    tick();
    rstN = 1'b0;
    #1;
    checkCount++; if (busA.o_abort !== 1'b0) $display("[TB] FAIL rstmid_abort_now: got %b expected 0", busA.o_abort); else passCount++;
    tick();
    #1;
    checkCount++; if (busA.o_empty !== 1'b1) $display("[TB] FAIL rstmid_empty: got %b expected 1", busA.o_empty); else passCount++;
    checkCount++; if (busA.o_count !== 3'd0) $display("[TB] FAIL rstmid_count: got %0d expected 0", busA.o_count); else passCount++;
    checkCount++; if (busA.o_pc_out !== 32'h0040_0004) $display("[TB] FAIL rstmid_pc: got %h expected 00400004", busA.o_pc_out); else passCount++;
    checkCount++; if (busA.o_abort !== 1'b0) $display("[TB] FAIL rstmid_abort: got %b expected 0", busA.o_abort); else passCount++;
    rstN = 1'b1;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rstN       = 1'b0;
    clearInputs();
    test_reset();
    test_basic();
    test_full();
    test_redirect();
    test_collide();
    test_sweep();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ifq_param.md
Name: ifq_param

Overview:
- Parametrised instruction fetch queue for the RISC-V front end; successor of the fixed 4-line/128-bit queue.
- Sits between i_cache and the dispatcher:
  - issues line-aligned cache reads;
  - buffers DEPTH cache lines of LINE_WORDS instructions;
  - presents one instruction per cycle with its PC+4;
  - flushes and redirects on a dispatcher jump/branch, with mid-line start.

Parameters:
- LINE_WORDS, 4, 32-bit instructions per cache line; power of 2, >=2.
- DEPTH, 4, cache lines buffered; power of 2, >=2.
- RESET_PC, 32'h0040_0000, fetch address after reset; word aligned.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- o_cache_addr  out  32  line-aligned fetch address {fetch_pc[31:OFF+2], (OFF+2)'b0}, where OFF=log2(LINE_WORDS).
- o_cache_rd_en  out  1  cache read request.
- o_abort  out  1  cancel the outstanding cache read.
- i_cache_dout  in  32*LINE_WORDS  line data; word k at bits [32k+31:32k].
- i_cache_dout_valid  in  1  line data valid, one-cycle pulse.
- i_rd_en  in  1  dispatcher consumes the current instruction.
- i_jmp_branch_address  in  32  redirect target; bits [1:0] ignored.
- i_jmp_branch_valid  in  1  redirect strobe, one-cycle pulse.
- o_instr  out  32  current instruction; 0 when empty.
- o_pc_out  out  32  PC of current instruction + 4.
- o_empty  out  1  no instruction available.
- o_count  out  log2(DEPTH)+1  lines held.

Behaviour:
- Reset (i_rst_n low at edge):
  - fetch_pc=RESET_PC; rd_pc=RESET_PC.
  - wptr, rptr, word_off, count, outstanding all 0.
  - Outputs: o_empty=1, o_instr=0, o_pc_out=RESET_PC+4, o_cache_rd_en=0, o_abort=0, o_count=0.
  - Storage array is not reset.
  - Reset mid-request drops the request with no abort; the cache is reset by the same i_rst_n.
- Request rule:
  - o_cache_rd_en = ~outstanding & (count+outstanding < DEPTH) & ~i_jmp_branch_valid, registered-free from state.
  - outstanding sets on the cycle o_cache_rd_en=1.
  - outstanding clears on i_cache_dout_valid.
  - o_cache_addr is stable while outstanding=1.
- Fill: on i_cache_dout_valid with no flush:
  - line written at wptr; wptr++ (wraps at DEPTH);
  - fetch_pc += 4*LINE_WORDS; count++.
- Read side:
  - o_empty = (count==0).
  - o_instr = line[rptr].word[word_off].
  - o_pc_out = rd_pc+4.
  - All combinational, zero latency from storage.
- Consume: i_rd_en & ~o_empty:
  - rd_pc += 4.
  - If word_off==LINE_WORDS-1: word_off=0, rptr++, count--. Otherwise word_off++.
  - i_rd_en while empty is ignored.
- Simultaneous fill and line retire: count unchanged; full-then-retire in the same cycle is legal.
- Data is usable the cycle after i_cache_dout_valid; there is no bypass.
- Redirect: i_jmp_branch_valid=1 (highest priority):
  - o_abort = i_jmp_branch_valid & outstanding, combinational, same cycle.
  - Next state: count=0, wptr=rptr=0, outstanding=0.
  - fetch_pc = rd_pc = {addr[31:2],2'b0}; word_off = addr[OFF+1:2].
  - A concurrent i_cache_dout_valid line is discarded.
  - A concurrent i_rd_en is ignored.
  - The new request issues the cycle after the redirect.
- Mid-line start: after a redirect, the first line's words below word_off are skipped. Later lines start at word 0.
- Fetch_pc wrap: wraps modulo 2^32 without error.
- Full: count+outstanding==DEPTH holds o_cache_rd_en=0 until a line retires.

Decomposition:
- Package ifq_pkg:
  - localparam helpers OFF_W=$clog2(LINE_WORDS) and PTR_W=$clog2(DEPTH);
  - LINE_BYTES;
  - typedef line_t as logic [LINE_WORDS-1:0][31:0];
  - function line_base(addr), which clears the low OFF_W+2 bits.
- Sub-module ifq_line_buf:
  - DEPTH x line_t storage with write port (wptr, we) and read port (rptr, word select);
  - pointer, count and flush logic stay in ifq_param.
  - One instance.

Test Plan:
- Reset, cache returns line 0..3 = 0x11,0x22,0x33,0x44 two cycles after the request, i_rd_en=1 held -> o_cache_addr=0x0040_0000; o_empty=0 the cycle after valid; o_instr 0x11..0x44 on consecutive cycles; o_pc_out 0x0040_0004..0x0040_0010.
- Never assert i_rd_en -> exactly DEPTH=4 requests at 0x0040_0000, 0x10, 0x20, 0x30; then o_cache_rd_en=0; o_count=4. Consume 4 words -> one new request at 0x0040_0040.
- i_jmp_branch_valid with address 0x0000_1008 while a request is outstanding -> o_abort=1 that cycle; next cycle o_cache_addr=0x0000_1000, o_empty=1. After fill, first o_instr=word 2 with o_pc_out=0x0000_100C.
- Redirect in the same cycle as i_cache_dout_valid and i_rd_en -> line discarded; rd_pc unchanged by the read; o_count=0 next cycle.
- Parameter sweep LINE_WORDS=8, DEPTH=2; redirect to 0xFFFF_FFFC -> o_cache_addr=0xFFFF_FFE0; word_off=7; next line fetch at 0x0000_0000 (wrap).
- Reset asserted mid-stream with o_count=3 -> next cycle o_empty=1, o_count=0, o_pc_out=0x0040_0004, o_abort=0.
